mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (legal range 2..64).
REQ-002 SHALL have port CLK  input  1  single clock, all state on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port START  input  1  request pulse; operands sampled when accepted.
REQ-005 SHALL have port SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
REQ-006 SHALL have port A  input  WIDTH  multiplicand.
REQ-007 SHALL have port B  input  WIDTH  multiplier.
REQ-008 SHALL have port HI  output  WIDTH  upper half of 2*WIDTH product.
REQ-009 SHALL have port LO  output  WIDTH  lower half of product.
REQ-010 SHALL have port BUSY  output  1  high in RUN and FIX.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse; HI/LO valid from this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-013 SHALL accept START only in IDLE or DONE; START in RUN/FIX ignored, operation undisturbed.
REQ-014 On acceptance SHALL latch |A|, |B| (magnitudes if SIGNED and MSB set, else raw), result sign = SIGNED & (A[MSB]^B[MSB]), clear (WIDTH+1)-bit accumulator and step counter, go to RUN.
REQ-015 RUN SHALL take exactly WIDTH cycles, one radix-2 shift-add step each: add multiplicand to accumulator when multiplier LSB=1, shift accumulator:multiplier right one bit.
REQ-016 After WIDTH-th step SHALL go to FIX; FIX SHALL two's-complement the 2*WIDTH product when sign=1 and register it into HI/LO, then go to DONE.
REQ-017 With START accepted at end of cycle N, DONE SHALL be high in cycle N+WIDTH+2 only (latency WIDTH+2).
REQ-018 DONE state SHALL last one cycle, then IDLE unless new START accepted (back-to-back allowed, then RUN).
REQ-019 HI/LO SHALL hold last result until next FIX (or zero-skip completion) overwrites them; HI/LO SHALL not change during RUN.
REQ-020 Most-negative x most-negative (signed) SHALL give exact positive product (magnitude fits WIDTH unsigned bits).
REQ-021 Step counter SHALL be $clog2(WIDTH) bits wide-enough to count WIDTH-1 without wrap.

Reset
REQ-022 RST high SHALL immediately force IDLE, HI=0, LO=0, BUSY=0, DONE=0, clear internal registers, at any state incl. mid-RUN.
REQ-023 First START after RST deassertion SHALL be accepted normally.

Configuration
REQ-024 Macro MULT_SEQ_ZERO_SKIP_EN defined: accepted operation with A=0 or B=0 SHALL bypass RUN/FIX, write HI=LO=0, DONE high in cycle N+1.
REQ-025 Macro undefined: zero operands SHALL follow normal WIDTH+2 latency path with result 0.

Structure
REQ-026 Package mult_pkg SHALL hold state enum typedef (IDLE/RUN/FIX/DONE) and MULT_DEFAULT_WIDTH=32.
REQ-027 SHALL instantiate parameterised sub-module twoscomp_n (width parameter) for operand magnitude and product negation; no other sub-modules.

Verification
REQ-028 WIDTH=32, SIGNED=0, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DONE exactly in cycle N+34, BUSY high N+1..N+33.
REQ-029 SIGNED=1, A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; same with SIGNED=0 -> HI=0x00000006, LO=0xFFFFFFEB.
REQ-030 SIGNED=1, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-031 START (A=2,B=3) then START (A=5,B=5) pulsed in cycle N+10 -> second ignored, result LO=6; RST in cycle N+15 -> all outputs 0 next sample, no DONE; fresh START -> correct result.
REQ-032 START in DONE cycle (A=4,B=4 after A=2,B=3) -> LO=6 on first DONE, LO=16 on DONE WIDTH+2 cycles later.
REQ-033 A=0, B=5: with MULT_SEQ_ZERO_SKIP_EN -> DONE in N+1, HI=LO=0; without -> DONE in N+34, HI=LO=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// the control FSM state encoding and the default operand width.
package mult_pkg;

    localparam int MULT_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/twoscomp_n.sv
// Conditional two's-complement of an N-bit vector. Used both to turn
// signed operands into magnitudes and to restore the product sign.
module twoscomp_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? (~x + N'(1'b1)) : x;

endmodule

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned operands.
// Latency is WIDTH+2 cycles from an accepted START to the DONE pulse.
// Optional build macro MULT_SEQ_ZERO_SKIP_EN: an operation with a zero
// operand completes in one cycle with a zero product.
module mult_seq #(
    parameter int WIDTH = mult_pkg::MULT_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE
);
    import mult_pkg::*;

    // The port DONE shadows the state literal, so that state is always
    // written with its package prefix.
    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t               state;
    state_t               next_state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       sum;
    logic [CW-1:0]        step;
    logic                 sign;
    logic                 accept;
    logic                 skip;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   product_fix;

    assign accept = START && ((state == IDLE) || (state == mult_pkg::DONE));

`ifdef MULT_SEQ_ZERO_SKIP_EN
    assign skip = (A == {WIDTH{1'b0}}) || (B == {WIDTH{1'b0}});
`else
    assign skip = 1'b0;
`endif

    // One shift-add step: the accumulator never exceeds 2^WIDTH-1 before
    // the add, so the extra accumulator bit absorbs the carry.
    assign sum     = acc + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign product = {acc[WIDTH-1:0], mplier};

    twoscomp_n #(.N(WIDTH)) u_mag_a (
        .x   (A),
        .neg (SIGNED & A[WIDTH-1]),
        .y   (mag_a)
    );

    twoscomp_n #(.N(WIDTH)) u_mag_b (
        .x   (B),
        .neg (SIGNED & B[WIDTH-1]),
        .y   (mag_b)
    );

    twoscomp_n #(.N(2*WIDTH)) u_neg_p (
        .x   (product),
        .neg (sign),
        .y   (product_fix)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH steps, FIX one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = skip ? mult_pkg::DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (step == LAST_STEP) begin
                    next_state = FIX;
                end else begin
                    next_state = RUN;
                end
            end
            FIX: begin
                next_state = mult_pkg::DONE;
            end
            mult_pkg::DONE: begin
                if (accept) begin
                    next_state = skip ? mult_pkg::DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            RUN, FIX: begin
                BUSY = 1'b1;
            end
            mult_pkg::DONE: begin
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
                DONE = 1'b0;
            end
        endcase
    end

    // Datapath: latch magnitudes on accept, shift-add in RUN, publish in FIX.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mcand  <= {WIDTH{1'b0}};
            mplier <= {WIDTH{1'b0}};
            acc    <= {(WIDTH+1){1'b0}};
            step   <= {CW{1'b0}};
            sign   <= 1'b0;
            HI     <= {WIDTH{1'b0}};
            LO     <= {WIDTH{1'b0}};
        end else if (accept) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= {(WIDTH+1){1'b0}};
            step   <= {CW{1'b0}};
            sign   <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            if (skip) begin
                HI <= {WIDTH{1'b0}};
                LO <= {WIDTH{1'b0}};
            end
        end else begin
            case (state)
                RUN: begin
                    acc    <= {1'b0, sum[WIDTH:1]};
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    step   <= step + CW'(1'b1);
                end
                FIX: begin
                    HI <= product_fix[2*WIDTH-1:WIDTH];
                    LO <= product_fix[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: a cycle-level behavioural model built
// from plain arithmetic checks DONE/BUSY/HI/LO on every falling edge, while
// directed and randomised stimulus exercise the corner cases.
module tb_mult_seq;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         SIGNED;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         BUSY;
    logic         DONE;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    logic           m_pend     = 1'b0;
    int             m_done_cyc = 0;
    logic [2*W-1:0] m_res      = '0;
    logic [2*W-1:0] m_shown    = '0;

    mult_seq #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SIGNED (SIGNED),
        .A      (A),
        .B      (B),
        .HI     (HI),
        .LO     (LO),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        if (a == '0 || b == '0) return 1;
`endif
        return W + 2;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return 1;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model and per-cycle comparison.
    initial begin : model_chk
        logic ed;
        logic eb;
        forever begin
            @(negedge CLK);
            ed = m_pend && (cyc == m_done_cyc);
            eb = m_pend && (cyc < m_done_cyc);
            if (RST) begin
                ed = 1'b0;
                eb = 1'b0;
                m_shown = '0;
            end else if (ed) begin
                m_shown = m_res;
            end
            chk("done", DONE, ed);
            chk("busy", BUSY, eb);
            chk("hi", HI, m_shown[2*W-1:W]);
            chk("lo", LO, m_shown[W-1:0]);
            if (RST) begin
                m_pend = 1'b0;
            end else begin
                if (ed) m_pend = 1'b0;
                if (START && !m_pend) begin
                    m_res      = ref_prod(A, B, SIGNED);
                    m_done_cyc = cyc + lat_of(A, B);
                    m_pend     = 1'b1;
                end
            end
        end
    end

    task automatic step_to(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            output int n);
        @(posedge CLK);
        #1;
        START = 1'b1; A = a; B = b; SIGNED = s;
        n = cyc;
        @(posedge CLK);
        #1;
        START = 1'b0; A = $urandom; B = $urandom; SIGNED = 1'($urandom);
    endtask

    task automatic wait_done(input int n, output int lat, output logic [W-1:0] hi,
                             output logic [W-1:0] lo);
        lat = -1; hi = '0; lo = '0;
        for (int i = 0; i < 100 && lat < 0; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                lat = cyc - n; hi = HI; lo = LO;
            end
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no DONE expected DONE within 100 cycles");
        end
    endtask

    initial begin
        int n;
        int n2;
        int lat;
        int ndone;
        logic [W-1:0] hi;
        logic [W-1:0] lo;

        RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_hi", HI, 0); chk("rst_lo", LO, 0);
        chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0);
        @(posedge CLK);
        #1 RST = 1'b0;

        chk("ref_signed", ref_prod(32'hFFFFFFFD, 32'd7, 1'b1), 64'hFFFFFFFF_FFFFFFEB);
        chk("ref_unsigned", ref_prod(32'hFFFFFFFD, 32'd7, 1'b0), 64'h00000006_FFFFFFEB);
        chk("ref_minmin", ref_prod(32'h80000000, 32'h80000000, 1'b1), 64'h40000000_00000000);

        // Largest unsigned product, first START after reset.
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n);
        wait_done(n, lat, hi, lo);
        chk("max_lat", lat, 34); chk("max_hi", hi, 32'hFFFFFFFE); chk("max_lo", lo, 32'h00000001);

        // -3 * 7 signed and unsigned.
        start_op(32'hFFFFFFFD, 32'd7, 1'b1, n);
        wait_done(n, lat, hi, lo);
        chk("s_hi", hi, 32'hFFFFFFFF); chk("s_lo", lo, 32'hFFFFFFEB);
        start_op(32'hFFFFFFFD, 32'd7, 1'b0, n);
        wait_done(n, lat, hi, lo);
        chk("u_hi", hi, 32'h00000006); chk("u_lo", lo, 32'hFFFFFFEB);

        // Most negative squared.
        start_op(32'h80000000, 32'h80000000, 1'b1, n);
        wait_done(n, lat, hi, lo);
        chk("mn_hi", hi, 32'h40000000); chk("mn_lo", lo, 32'h00000000);

        // START while busy is ignored.
        start_op(32'd2, 32'd3, 1'b0, n);
        step_to(n + 10);
        START = 1'b1; A = 32'd5; B = 32'd5;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done(n, lat, hi, lo);
        chk("ign_lat", lat, 34); chk("ign_lo", lo, 32'd6); chk("ign_hi", hi, 32'd0);

        // Reset in the middle of RUN.
        start_op(32'd7, 32'd7, 1'b0, n);
        step_to(n + 15);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_hi", HI, 0); chk("mid_rst_lo", LO, 0);
        chk("mid_rst_busy", BUSY, 0); chk("mid_rst_done", DONE, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE === 1'b1) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);
        start_op(32'd6, 32'hFFFFFFF9, 1'b1, n);
        wait_done(n, lat, hi, lo);
        chk("post_rst_hi", hi, 32'hFFFFFFFF); chk("post_rst_lo", lo, 32'hFFFFFFD6);

        // Back-to-back: new START during the DONE cycle.
        start_op(32'd2, 32'd3, 1'b0, n);
        step_to(n + W + 2);
        START = 1'b1; A = 32'd4; B = 32'd4; SIGNED = 1'b0;
        n2 = cyc;
        @(negedge CLK);
        chk("b2b_done1", DONE, 1); chk("b2b_lo1", LO, 32'd6);
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done(n2, lat, hi, lo);
        chk("b2b_lat2", lat, 34); chk("b2b_lo2", lo, 32'd16);

        // Zero operand.
        start_op(32'd0, 32'd5, 1'b0, n);
        wait_done(n, lat, hi, lo);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        chk("zero_lat", lat, 1);
`else
        chk("zero_lat", lat, 34);
`endif
        chk("zero_hi", hi, 0); chk("zero_lo", lo, 0);

        // Randomised traffic, including starts while busy and rare resets.
        repeat (3000) begin
            @(posedge CLK);
            #1;
            START  = ($urandom_range(0, 7) == 0);
            A      = pick();
            B      = pick();
            SIGNED = 1'($urandom_range(0, 1));
            RST    = ($urandom_range(0, 599) == 0);
        end
        @(posedge CLK);
        #1;
        START = 1'b0;
        RST   = 1'b0;
        repeat (40) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
